// File: rtl/shared_vc_allocator.sv
// Per-bank shared-VC manager: hands free shared VCs to the port owning the bank,
// tracks per-VC ownership and flit occupancy. The per-VC release input is named
// release_vc because "release" is a reserved word in SystemVerilog.
module shared_vc_allocator #(
    parameter int num_ports        = 5,
    parameter int num_vcs_per_bank = 2,
    parameter int vc_idx_width     = 1,
    parameter int buffer_depth     = 8,
    parameter int occ_width        = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [num_ports-1:0]                  memory_bank_grant,
    input  logic                                  ready_for_allocation,
    input  logic [num_ports-1:0]                  alloc_req,
    output logic [num_ports-1:0]                  alloc_gnt,
    output logic [vc_idx_width-1:0]               alloc_vc,
    input  logic [num_vcs_per_bank-1:0]           release_vc,
    input  logic [num_vcs_per_bank-1:0]           flit_wr,
    input  logic [num_vcs_per_bank-1:0]           flit_rd,
    output logic [num_ports*num_vcs_per_bank-1:0] allocated_ip_shared_ivc,
    output logic [num_vcs_per_bank-1:0]           shared_ivc_empty,
    output logic                                  overflow_err,
    output logic                                  underflow_err
);

    localparam int port_idx_width = (num_ports > 1) ? $clog2(num_ports) : 1;
    localparam logic [occ_width-1:0] occ_one  = occ_width'(1);
    localparam logic [occ_width-1:0] occ_zero = occ_width'(0);
    localparam logic [occ_width-1:0] occ_full = occ_width'(buffer_depth);

    typedef enum logic [1:0] {
        VC_FREE  = 2'd0,
        VC_ALLOC = 2'd1,
        VC_DRAIN = 2'd2
    } vc_state_e;

    vc_state_e                 r_state     [num_vcs_per_bank];
    vc_state_e                 w_state_nxt [num_vcs_per_bank];
    logic [port_idx_width-1:0] r_owner     [num_vcs_per_bank];
    logic [port_idx_width-1:0] w_owner_nxt [num_vcs_per_bank];
    logic [occ_width-1:0]      r_occ       [num_vcs_per_bank];

    logic [num_vcs_per_bank-1:0] w_full;
    logic [num_vcs_per_bank-1:0] w_empty;
    logic [port_idx_width-1:0]   w_port_idx;
    logic [vc_idx_width-1:0]     w_free_idx;
    logic                        w_free_any;
    logic                        w_alloc_fire;
    logic                        w_ovf_any;
    logic                        w_udf_any;

    // Grant port index, lowest free VC, occupancy flags and the allocation decision.
    always_comb begin
        w_port_idx = '0;
        w_free_idx = '0;
        w_free_any = 1'b0;
        for (int p = num_ports - 1; p >= 0; p--) begin
            w_port_idx = memory_bank_grant[p] ? port_idx_width'(p) : w_port_idx;
        end
        for (int i = num_vcs_per_bank - 1; i >= 0; i--) begin
            w_free_idx = (r_state[i] == VC_FREE) ? vc_idx_width'(i) : w_free_idx;
            w_free_any = w_free_any | (r_state[i] == VC_FREE);
            w_full[i]  = (r_occ[i] == occ_full);
            w_empty[i] = (r_occ[i] == occ_zero);
        end
        // The ~|alloc_gnt term forces a gap cycle so a held request cannot be granted twice.
        w_alloc_fire = ready_for_allocation && $onehot(memory_bank_grant)
                       && (|(alloc_req & memory_bank_grant)) && w_free_any && !(|alloc_gnt);
        w_ovf_any = |(flit_wr & ~flit_rd & w_full);
        w_udf_any = |(flit_rd & ~flit_wr & w_empty);
    end

    // Per-VC next state and owner.
    always_comb begin
        for (int i = 0; i < num_vcs_per_bank; i++) begin
            w_state_nxt[i] = r_state[i];
            w_owner_nxt[i] = r_owner[i];
            case (r_state[i])
                VC_FREE: begin
                    if (w_alloc_fire && (w_free_idx == vc_idx_width'(i))) begin
                        w_state_nxt[i] = VC_ALLOC;
                        w_owner_nxt[i] = w_port_idx;
                    end else begin
                        w_state_nxt[i] = VC_FREE;
                    end
                end
                VC_ALLOC: begin
                    if (release_vc[i]) begin
                        w_state_nxt[i] = VC_DRAIN;
                    end else begin
                        w_state_nxt[i] = VC_ALLOC;
                    end
                end
                VC_DRAIN: begin
                    if (w_empty[i]) begin
                        w_state_nxt[i] = VC_FREE;
                    end else begin
                        w_state_nxt[i] = VC_DRAIN;
                    end
                end
                default: w_state_nxt[i] = VC_FREE;
            endcase
        end
    end

    // Per-VC state and owner registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                r_state[i] <= VC_FREE;
                r_owner[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_owner[i] <= w_owner_nxt[i];
            end
        end
    end

    // Occupancy counters; a simultaneous write and read only moves the count at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                r_occ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                case ({flit_wr[i], flit_rd[i]})
                    2'b10:   r_occ[i] <= w_full[i]  ? r_occ[i] : r_occ[i] + occ_one;
                    2'b01:   r_occ[i] <= w_empty[i] ? r_occ[i] : r_occ[i] - occ_one;
                    2'b11:   r_occ[i] <= w_empty[i] ? occ_one  : r_occ[i];
                    default: r_occ[i] <= r_occ[i];
                endcase
            end
        end
    end

    // Grant pulse, granted VC index and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_gnt     <= '0;
            alloc_vc      <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                alloc_gnt <= memory_bank_grant;
                alloc_vc  <= w_free_idx;
            end else begin
                alloc_gnt <= '0;
            end
            overflow_err  <= overflow_err | w_ovf_any;
            underflow_err <= underflow_err | w_udf_any;
        end
    end

    // Ownership map and empty flags decoded from registered state.
    always_comb begin
        allocated_ip_shared_ivc = '0;
        for (int p = 0; p < num_ports; p++) begin
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                allocated_ip_shared_ivc[p*num_vcs_per_bank+i] =
                    (r_state[i] != VC_FREE) && (r_owner[i] == port_idx_width'(p));
            end
        end
        shared_ivc_empty = w_empty;
    end

endmodule

// File: tb/tb_shared_vc_allocator.sv
// Directed bench for shared_vc_allocator (5 ports, 2 shared VCs, depth 8).
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_shared_vc_allocator;

    logic       clk;
    logic       reset;
    logic [4:0] memory_bank_grant;
    logic       ready_for_allocation;
    logic [4:0] alloc_req;
    logic [4:0] alloc_gnt;
    logic [0:0] alloc_vc;
    logic [1:0] release_vc;
    logic [1:0] flit_wr;
    logic [1:0] flit_rd;
    logic [9:0] allocated_ip_shared_ivc;
    logic [1:0] shared_ivc_empty;
    logic       overflow_err;
    logic       underflow_err;

    int n_checks = 0;
    int n_errors = 0;

    shared_vc_allocator dut (
        .clk                     (clk),
        .reset                   (reset),
        .memory_bank_grant       (memory_bank_grant),
        .ready_for_allocation    (ready_for_allocation),
        .alloc_req               (alloc_req),
        .alloc_gnt               (alloc_gnt),
        .alloc_vc                (alloc_vc),
        .release_vc              (release_vc),
        .flit_wr                 (flit_wr),
        .flit_rd                 (flit_rd),
        .allocated_ip_shared_ivc (allocated_ip_shared_ivc),
        .shared_ivc_empty        (shared_ivc_empty),
        .overflow_err            (overflow_err),
        .underflow_err           (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gnt"},   32'(alloc_gnt), 32'h0);
        chk({tag, "_vc"},    32'(alloc_vc), 32'h0);
        chk({tag, "_own"},   32'(allocated_ip_shared_ivc), 32'h0);
        chk({tag, "_empty"}, 32'(shared_ivc_empty), 32'h3);
        chk({tag, "_ovf"},   32'(overflow_err), 32'h0);
        chk({tag, "_udf"},   32'(underflow_err), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        memory_bank_grant = 5'b00000;
        ready_for_allocation = 1'b0;
        alloc_req = 5'b00000;
        release_vc = 2'b00;
        flit_wr = 2'b00;
        flit_rd = 2'b00;
        #3;
        chk_reset_state("rst");
        step();
        step();
        reset = 1'b0;

        // Basic grant to port 2 -> VC0, ownership bit 4
        memory_bank_grant = 5'b00100;
        ready_for_allocation = 1'b1;
        alloc_req = 5'b00100;
        step();
        chk("basic_gnt", 32'(alloc_gnt), 32'h04);
        chk("basic_vc",  32'(alloc_vc), 32'h0);
        chk("basic_own", 32'(allocated_ip_shared_ivc), 32'h010);
        alloc_req = 5'b00000;
        step();
        chk("basic_gnt_low", 32'(alloc_gnt), 32'h00);
        chk("basic_own_hold", 32'(allocated_ip_shared_ivc), 32'h010);

        // Held request: grants at cycles 1 and 3 only
        do_reset();
        alloc_req = 5'b00100;
        step();
        chk("b2b_g1", 32'(alloc_gnt), 32'h04);
        chk("b2b_v1", 32'(alloc_vc), 32'h0);
        step();
        chk("b2b_gap", 32'(alloc_gnt), 32'h00);
        step();
        chk("b2b_g3", 32'(alloc_gnt), 32'h04);
        chk("b2b_v3", 32'(alloc_vc), 32'h1);
        chk("b2b_own", 32'(allocated_ip_shared_ivc), 32'h030);
        step();
        chk("b2b_c4", 32'(alloc_gnt), 32'h00);
        chk("b2b_vc_hold", 32'(alloc_vc), 32'h1);
        step();
        chk("b2b_full", 32'(alloc_gnt), 32'h00);
        alloc_req = 5'b00000;

        // Blocked allocations
        do_reset();
        memory_bank_grant = 5'b10000;
        alloc_req = 5'b01000;
        step();
        step();
        chk("blk_port", 32'(alloc_gnt), 32'h00);
        chk("blk_port_own", 32'(allocated_ip_shared_ivc), 32'h000);
        memory_bank_grant = 5'b01000;
        ready_for_allocation = 1'b0;
        step();
        step();
        chk("blk_ready", 32'(alloc_gnt), 32'h00);
        ready_for_allocation = 1'b1;
        memory_bank_grant = 5'b11000;
        alloc_req = 5'b11000;
        step();
        step();
        chk("blk_onehot", 32'(alloc_gnt), 32'h00);
        chk("blk_onehot_own", 32'(allocated_ip_shared_ivc), 32'h000);
        memory_bank_grant = 5'b01000;
        alloc_req = 5'b01000;
        step();
        chk("pend_gnt", 32'(alloc_gnt), 32'h08);
        chk("pend_own", 32'(allocated_ip_shared_ivc), 32'h040);
        alloc_req = 5'b00000;

        // Release and drain of VC0 holding 3 flits
        do_reset();
        memory_bank_grant = 5'b00100;
        alloc_req = 5'b00100;
        step();
        chk("drn_gnt", 32'(alloc_gnt), 32'h04);
        alloc_req = 5'b00000;
        flit_wr = 2'b01;
        step();
        chk("drn_empty_w1", 32'(shared_ivc_empty), 32'h2);
        step();
        step();
        flit_wr = 2'b00;
        release_vc = 2'b01;
        step();
        release_vc = 2'b00;
        chk("drn_own_rel", 32'(allocated_ip_shared_ivc), 32'h010);
        flit_rd = 2'b01;
        step();
        step();
        chk("drn_empty_r2", 32'(shared_ivc_empty), 32'h2);
        step();
        flit_rd = 2'b00;
        chk("drn_empty_r3", 32'(shared_ivc_empty), 32'h3);
        chk("drn_own_r3", 32'(allocated_ip_shared_ivc), 32'h010);
        step();
        chk("drn_freed", 32'(allocated_ip_shared_ivc), 32'h000);
        chk("drn_udf", 32'(underflow_err), 32'h0);
        memory_bank_grant = 5'b00010;
        alloc_req = 5'b00010;
        step();
        alloc_req = 5'b00000;
        chk("drn_regnt", 32'(alloc_gnt), 32'h02);
        chk("drn_regnt_vc", 32'(alloc_vc), 32'h0);
        chk("drn_regnt_own", 32'(allocated_ip_shared_ivc), 32'h004);
        // Release at occupancy 0 frees over two edges
        release_vc = 2'b01;
        step();
        release_vc = 2'b00;
        chk("rel0_drain", 32'(allocated_ip_shared_ivc), 32'h004);
        step();
        chk("rel0_free", 32'(allocated_ip_shared_ivc), 32'h000);

        // Counter boundaries on VC1
        do_reset();
        ready_for_allocation = 1'b0;
        flit_wr = 2'b10;
        for (int k = 0; k < 8; k++) step();
        chk("ovf_8_empty", 32'(shared_ivc_empty), 32'h1);
        chk("ovf_8_flag", 32'(overflow_err), 32'h0);
        step();
        chk("ovf_9_flag", 32'(overflow_err), 32'h1);
        flit_rd = 2'b10;
        step();
        chk("ovf_wrrd_flag", 32'(overflow_err), 32'h1);
        chk("ovf_wrrd_udf", 32'(underflow_err), 32'h0);
        flit_wr = 2'b00;
        for (int k = 0; k < 7; k++) step();
        chk("rd7_empty", 32'(shared_ivc_empty), 32'h1);
        step();
        chk("rd8_empty", 32'(shared_ivc_empty), 32'h3);
        flit_wr = 2'b10;
        step();
        chk("wrrd0_empty", 32'(shared_ivc_empty), 32'h1);
        chk("wrrd0_udf", 32'(underflow_err), 32'h0);
        flit_wr = 2'b00;
        step();
        chk("rd_to0_empty", 32'(shared_ivc_empty), 32'h3);
        chk("rd_to0_udf", 32'(underflow_err), 32'h0);
        step();
        flit_rd = 2'b00;
        chk("udf_flag", 32'(underflow_err), 32'h1);
        chk("udf_empty", 32'(shared_ivc_empty), 32'h3);

        // Async reset mid-grant with both VCs allocated and errors set
        ready_for_allocation = 1'b1;
        memory_bank_grant = 5'b00100;
        alloc_req = 5'b00100;
        step();
        step();
        step();
        chk("ar_pre_gnt", 32'(alloc_gnt), 32'h04);
        chk("ar_pre_vc", 32'(alloc_vc), 32'h1);
        chk("ar_pre_own", 32'(allocated_ip_shared_ivc), 32'h030);
        reset = 1'b1;
        #1;
        chk_reset_state("ar");
        alloc_req = 5'b00000;
        #1;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
